// File: rtl/mem_axil_master.sv
// Single-outstanding load/store bridge from a simple core request port to an AXI4-Lite master.
// Sub-word accesses are aligned onto the 32-bit bus; load data is extracted and extended on return.
module mem_axil_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_READ  = 3'd3,
    S_RDATA = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  function automatic logic f_bad(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    f_bad = 1'b0;
      2'd1:    f_bad = lo[0];
      2'd2:    f_bad = (lo != 2'b00);
      default: f_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] f_strb(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    f_strb = 4'b0001 << lo;
      2'd1:    f_strb = 4'b0011 << lo;
      default: f_strb = 4'b1111;
    endcase
  endfunction

  // Shift the addressed lane down, then truncate and extend according to size and signedness.
  function automatic logic [31:0] f_extend(input logic [31:0] data, input logic [1:0] lo,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] lane;
    lane = data >> {lo, 3'b000};
    case (size)
      2'd0:    f_extend = uns ? {24'h000000, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'd1:    f_extend = uns ? {16'h0000, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: f_extend = lane;
    endcase
  endfunction

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_arvalid;
  logic                  w_awvalid_next;
  logic                  w_wvalid_next;
  logic                  w_arvalid_next;
  logic [1:0]            r_addr_lo;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_axaddr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_error;
  logic                  w_bad;
  logic                  w_accept;

  assign w_bad    = f_bad(req_size, req_addr[1:0]);
  assign w_accept = (r_state == S_IDLE) && req_valid;

  // State and AXI valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_awvalid <= w_awvalid_next;
      r_wvalid  <= w_wvalid_next;
      r_arvalid <= w_arvalid_next;
    end
  end

  // Next-state logic; AW and W retire independently while in WRITE
  always_comb begin
    w_state_next   = r_state;
    w_awvalid_next = r_awvalid;
    w_wvalid_next  = r_wvalid;
    w_arvalid_next = r_arvalid;
    case (r_state)
      S_IDLE: begin
        if (!req_valid) begin
          w_state_next = S_IDLE;
        end else if (w_bad) begin
          w_state_next = S_RESP;
        end else if (req_write) begin
          w_state_next   = S_WRITE;
          w_awvalid_next = 1'b1;
          w_wvalid_next  = 1'b1;
        end else begin
          w_state_next   = S_READ;
          w_arvalid_next = 1'b1;
        end
      end
      S_WRITE: begin
        w_awvalid_next = r_awvalid & ~m_axil_awready;
        w_wvalid_next  = r_wvalid & ~m_axil_wready;
        if (!w_awvalid_next && !w_wvalid_next) begin
          w_state_next = S_WRESP;
        end else begin
          w_state_next = S_WRITE;
        end
      end
      S_WRESP: begin
        if (m_axil_bvalid) begin
          w_state_next = S_RESP;
        end else begin
          w_state_next = S_WRESP;
        end
      end
      S_READ: begin
        if (m_axil_arready) begin
          w_state_next   = S_RDATA;
          w_arvalid_next = 1'b0;
        end else begin
          w_state_next = S_READ;
        end
      end
      S_RDATA: begin
        if (m_axil_rvalid) begin
          w_state_next = S_RESP;
        end else begin
          w_state_next = S_RDATA;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_RESP;
        end
      end
      default: begin
        w_state_next   = S_IDLE;
        w_awvalid_next = 1'b0;
        w_wvalid_next  = 1'b0;
        w_arvalid_next = 1'b0;
      end
    endcase
  end

  // Request capture at acceptance and response capture on B/R handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_lo   <= 2'b00;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_axaddr    <= '0;
      r_wdata     <= 32'h0000_0000;
      r_wstrb     <= 4'b0000;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_error <= 1'b0;
    end else if (w_accept) begin
      r_addr_lo   <= req_addr[1:0];
      r_size      <= req_size;
      r_unsigned  <= req_unsigned;
      r_axaddr    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
      r_wdata     <= req_wdata << {req_addr[1:0], 3'b000};
      r_wstrb     <= f_strb(req_size, req_addr[1:0]);
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_error <= w_bad;
    end else if ((r_state == S_WRESP) && m_axil_bvalid) begin
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_error <= (m_axil_bresp != 2'b00);
    end else if ((r_state == S_RDATA) && m_axil_rvalid) begin
      r_rsp_rdata <= (m_axil_rresp != 2'b00) ? 32'h0000_0000
                                             : f_extend(m_axil_rdata, r_addr_lo, r_size, r_unsigned);
      r_rsp_error <= (m_axil_rresp != 2'b00);
    end
  end

  // Reset masks the handshake outputs combinationally so they are low for the whole reset window
  assign req_ready      = (r_state == S_IDLE) && !rst;
  assign rsp_valid      = (r_state == S_RESP) && !rst;
  assign rsp_rdata      = rst ? 32'h0000_0000 : r_rsp_rdata;
  assign rsp_error      = r_rsp_error && !rst;
  assign m_axil_awaddr  = r_axaddr;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = r_awvalid && !rst;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = r_wstrb;
  assign m_axil_wvalid  = r_wvalid && !rst;
  assign m_axil_bready  = (r_state == S_WRESP) && !rst;
  assign m_axil_araddr  = r_axaddr;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = r_arvalid && !rst;
  assign m_axil_rready  = (r_state == S_RDATA) && !rst;

endmodule

// File: tb/tb_mem_axil_master.sv
// Directed bench for mem_axil_master with a small AXI4-Lite slave whose ready delays and responses are set per test.
module tb_mem_axil_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int          checks = 0;
  int          errors = 0;

  // slave configuration and observation
  int          aw_lat, w_lat;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic [31:0] rdata_cfg;
  logic        r_block;
  int          aw_cnt, w_cnt;
  logic        aw_got, w_got;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  int          ar_seen = 0;
  int          aw_seen = 0;
  int          wonly_seen = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          base;

  always #5 clk = ~clk;

  mem_axil_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  assign awready = awvalid && (aw_cnt >= aw_lat);
  assign wready  = wvalid && (w_cnt >= w_lat);
  assign arready = arvalid;
  assign bresp   = bresp_cfg;
  assign rresp   = rresp_cfg;
  assign rdata   = rdata_cfg;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_cnt <= 0; aw_got <= 1'b1; cap_awaddr <= awaddr;
      end else if (awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready) begin
        w_cnt <= 0; w_got <= 1'b1; cap_wdata <= wdata; cap_wstrb <= wstrb;
      end else if (wvalid) begin
        w_cnt <= w_cnt + 1;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end else if (aw_got && w_got) begin
        bvalid <= 1'b1;
      end
      if (arvalid && arready) begin
        cap_araddr <= araddr; rvalid <= !r_block;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (arvalid) ar_seen++;
    if (awvalid || wvalid) aw_seen++;
    if (!awvalid && wvalid) wonly_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request/response round trip; request inputs are scrambled right after acceptance.
  task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] sz, input logic u,
                       input logic [31:0] wd, output logic [31:0] o_rd, output logic o_er,
                       output int o_lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz;
    req_unsigned = u; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~w; req_addr = 32'hFFFF_FFFF; req_size = 2'd3;
    req_unsigned = ~u; req_wdata = 32'h5A5A_5A5A;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 60);
    check("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    o_lat = n; o_rd = rsp_rdata; o_er = rsp_error;
    @(negedge clk);
    check("rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("req_ready_after_rsp", {31'd0, req_ready}, 32'd1);
    check("rsp_valid_dropped", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b0;
    aw_lat = 0; w_lat = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
    rdata_cfg = 32'h0; r_block = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);
    check("prot", {26'd0, awprot, arprot}, 32'd0);

    // word store, zero-wait slave
    issue(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, rd, er, lat);
    check("sw_awaddr", cap_awaddr, 32'h10);
    check("sw_wstrb", {28'd0, cap_wstrb}, 32'hF);
    check("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
    check("sw_rdata", rd, 32'h0);
    check("sw_error", {31'd0, er}, 32'd0);
    check("sw_latency", lat, 32'd4);

    // byte store to the top lane
    issue(1'b1, 32'h13, 2'd0, 1'b0, 32'h0000_00A5, rd, er, lat);
    check("sb_awaddr", cap_awaddr, 32'h10);
    check("sb_wstrb", {28'd0, cap_wstrb}, 32'h8);
    check("sb_wdata_hi", {24'd0, cap_wdata[31:24]}, 32'hA5);
    check("sb_error", {31'd0, er}, 32'd0);

    // half store to the upper half
    issue(1'b1, 32'h2, 2'd1, 1'b0, 32'h1234_BEEF, rd, er, lat);
    check("sh_awaddr", cap_awaddr, 32'h0);
    check("sh_wstrb", {28'd0, cap_wstrb}, 32'hC);
    check("sh_wdata", cap_wdata, 32'hBEEF_0000);

    // half loads, signed and unsigned
    rdata_cfg = 32'h8001_1234;
    issue(1'b0, 32'h12, 2'd1, 1'b0, 32'h0, rd, er, lat);
    check("lh_araddr", cap_araddr, 32'h10);
    check("lh_rdata", rd, 32'hFFFF_8001);
    check("lh_error", {31'd0, er}, 32'd0);
    check("lh_latency", lat, 32'd3);
    issue(1'b0, 32'h12, 2'd1, 1'b1, 32'h0, rd, er, lat);
    check("lhu_rdata", rd, 32'h0000_8001);

    // byte loads
    issue(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, rd, er, lat);
    check("lb_rdata", rd, 32'hFFFF_FF80);
    issue(1'b0, 32'h10, 2'd0, 1'b1, 32'h0, rd, er, lat);
    check("lbu_rdata", rd, 32'h0000_0034);

    // word load with SLVERR
    rresp_cfg = 2'b10;
    issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, rd, er, lat);
    check("lw_slverr_error", {31'd0, er}, 32'd1);
    check("lw_slverr_rdata", rd, 32'h0);
    rresp_cfg = 2'b00;

    // misaligned word load: no AR, error on the next cycle
    base = ar_seen;
    issue(1'b0, 32'h6, 2'd2, 1'b0, 32'h0, rd, er, lat);
    check("mis_error", {31'd0, er}, 32'd1);
    check("mis_rdata", rd, 32'h0);
    check("mis_latency", lat, 32'd1);
    check("mis_no_ar", ar_seen - base, 32'd0);

    // illegal size store: no AW/W
    base = aw_seen;
    issue(1'b1, 32'h0, 2'd3, 1'b0, 32'h1111_1111, rd, er, lat);
    check("ill_error", {31'd0, er}, 32'd1);
    check("ill_latency", lat, 32'd1);
    check("ill_no_aw", aw_seen - base, 32'd0);

    // W delayed 3 cycles behind AW, SLVERR on B
    aw_lat = 0; w_lat = 3; bresp_cfg = 2'b10;
    base = wonly_seen;
    issue(1'b1, 32'h40, 2'd2, 1'b0, 32'hCAFE_F00D, rd, er, lat);
    check("wdly_w_only_cycles", wonly_seen - base, 32'd3);
    check("wdly_error", {31'd0, er}, 32'd1);
    check("wdly_rdata", rd, 32'h0);
    check("wdly_wdata", cap_wdata, 32'hCAFE_F00D);
    w_lat = 0; bresp_cfg = 2'b00;

    // reset while waiting in RDATA
    r_block = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h30; req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rready) break;
    end
    check("rdata_reached", {31'd0, rready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    check("midrst_valids", {26'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 32'd0);
    rst = 1'b0;
    r_block = 1'b0;
    #1;
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    base = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid || arvalid || rready) base++;
    end
    check("post_rst_quiet", base, 32'd0);

    // normal operation after the abandoned transaction
    issue(1'b0, 32'h12, 2'd1, 1'b1, 32'h0, rd, er, lat);
    check("post_rst_lhu", rd, 32'h0000_8001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
